// File: rtl/acc_muldiv_unit_if.sv
// Handshake/operand bundle between the control unit (master) and the mul/div unit (slave).
interface acc_muldiv_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] acc_in;
  logic [WIDTH-1:0] opnd_in;
  logic             busy;
  logic             done;
  logic             reg_w;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             div0;

  modport master (
    output start, op, acc_in, opnd_in,
    input  busy, done, reg_w, result, ovf, div0
  );

  modport slave (
    input  start, op, acc_in, opnd_in,
    output busy, done, reg_w, result, ovf, div0
  );
endinterface

// File: rtl/acc_muldiv_unit.sv
// Iterative signed multiply/divide feeding the accumulator, one bit per cycle.
// Define ACC_MULDIV_DIV_EN to build the divider; otherwise DIV/REM act as the reserved op.
module acc_muldiv_unit #(
  parameter int unsigned WIDTH = 16
) (
  input logic              CLK,
  input logic              reset,
  acc_muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OpMul = 2'b00;
`ifdef ACC_MULDIV_DIV_EN
  localparam logic [1:0] OpDiv = 2'b01;
  localparam logic [1:0] OpRem = 2'b10;
  localparam logic [WIDTH-1:0] MinMag = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] OneW   = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state;
  logic [1:0]         r_op;
  logic               r_sa, r_sb;
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_busy, r_done, r_reg_w, r_ovf, r_div0;
  logic [WIDTH-1:0]   r_result;

  // Magnitudes are unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_a_mag = bus.acc_in[WIDTH-1]  ? -bus.acc_in  : bus.acc_in;
  assign w_b_mag = bus.opnd_in[WIDTH-1] ? -bus.opnd_in : bus.opnd_in;

  // Shift-add: high half accumulates, multiplier bits retire from the low end.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_nxt, w_prod_s;
  logic               w_mul_ovf;
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};
  assign w_prod_s   = (r_sa ^ r_sb) ? -r_prod : r_prod;
  assign w_mul_ovf  = (w_prod_s[2*WIDTH-1:WIDTH-1] != '0) &&
                      (w_prod_s[2*WIDTH-1:WIDTH-1] != '1);

`ifdef ACC_MULDIV_DIV_EN
  logic [WIDTH-1:0] r_b, r_quo;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   w_shift;
  logic             w_ge, w_b_zero;
  logic [WIDTH-1:0] w_quo_s, w_rem_s;
  assign w_shift  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_b});
  assign w_b_zero = (r_b == '0);
  assign w_quo_s  = (r_sa ^ r_sb) ? -r_quo : r_quo;
  assign w_rem_s  = r_sa ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
`endif

  logic [WIDTH-1:0] w_fin_result;
  logic             w_fin_ovf, w_fin_div0, w_fin_wr;

  always_comb begin
    w_fin_result = '0;
    w_fin_ovf    = 1'b0;
    w_fin_div0   = 1'b0;
    w_fin_wr     = 1'b0;
    case (r_op)
      OpMul: begin
        w_fin_result = w_prod_s[WIDTH-1:0];
        w_fin_ovf    = w_mul_ovf;
        w_fin_wr     = 1'b1;
      end
`ifdef ACC_MULDIV_DIV_EN
      OpDiv: begin
        // Raw quotient of x/0 is all ones in magnitude; force -1 regardless of sign.
        w_fin_result = w_b_zero ? '1 : w_quo_s;
        w_fin_div0   = w_b_zero;
        w_fin_ovf    = r_sa && r_sb && (r_a == MinMag) && (r_b == OneW);
        w_fin_wr     = 1'b1;
      end
      OpRem: begin
        w_fin_result = w_rem_s;
        w_fin_div0   = w_b_zero;
        w_fin_wr     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_a      <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_reg_w  <= 1'b0;
      r_ovf    <= 1'b0;
      r_div0   <= 1'b0;
      r_result <= '0;
`ifdef ACC_MULDIV_DIV_EN
      r_b      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_reg_w <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state <= StRun;
            r_busy  <= 1'b1;
            r_op    <= bus.op;
            r_sa    <= bus.acc_in[WIDTH-1];
            r_sb    <= bus.opnd_in[WIDTH-1];
            r_a     <= w_a_mag;
            r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_div0  <= 1'b0;
`ifdef ACC_MULDIV_DIV_EN
            r_b     <= w_b_mag;
            r_quo   <= w_a_mag;
            r_rem   <= '0;
`endif
          end
        end
        StRun: begin
          if (r_cnt != CW'(WIDTH)) begin
            r_prod <= w_prod_nxt;
            r_cnt  <= r_cnt + CW'(1);
`ifdef ACC_MULDIV_DIV_EN
            r_rem  <= w_ge ? (w_shift - {1'b0, r_b}) : w_shift;
            r_quo  <= {r_quo[WIDTH-2:0], w_ge};
`endif
          end else begin
            // Sign fix-up and result commit happen on the extra edge after the last bit.
            r_state  <= StDone;
            r_done   <= 1'b1;
            r_reg_w  <= w_fin_wr;
            r_result <= w_fin_result;
            r_ovf    <= w_fin_ovf;
            r_div0   <= w_fin_div0;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.reg_w  = r_reg_w;
  assign bus.result = r_result;
  assign bus.ovf    = r_ovf;
  assign bus.div0   = r_div0;

endmodule

// File: tb/tb_acc_muldiv_unit.sv
// Scoreboard bench for acc_muldiv_unit: driver queues expected results, monitor checks on done.
module tb_acc_muldiv_unit;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        ovf;
    logic        div0;
    logic        wr;
  } exp_t;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];

  acc_muldiv_unit_if #(.WIDTH(16)) bus ();

  acc_muldiv_unit #(.WIDTH(16)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge CLK) begin
    if (!reset) begin
      if (bus.done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk({e.name, ".result"}, {16'h0, bus.result}, {16'h0, e.res});
          chk({e.name, ".ovf"},    {31'h0, bus.ovf},    {31'h0, e.ovf});
          chk({e.name, ".div0"},   {31'h0, bus.div0},   {31'h0, e.div0});
          chk({e.name, ".reg_w"},  {31'h0, bus.reg_w},  {31'h0, e.wr});
        end
      end else if (bus.reg_w) begin
        chk("reg_w_without_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] res, input logic ovf,
                        input logic div0, input logic wr, input bit repulse);
    exp_t e;
    int   k;
    bit   got;
    e.name = name; e.res = res; e.ovf = ovf; e.div0 = div0; e.wr = wr;
    sb_q.push_back(e);
    @(negedge CLK);
    bus.start = 1'b1; bus.op = op; bus.acc_in = a; bus.opnd_in = b;
    @(posedge CLK); #1;
    k = edge_cnt;
    // Scramble the operands after acceptance; they must not matter.
    bus.start = 1'b0; bus.op = 2'b11; bus.acc_in = 16'hA5A5; bus.opnd_in = 16'h5A5A;
    chk({name, ".busy_on_accept"}, {31'h0, bus.busy}, 32'd1);
    chk({name, ".ovf_cleared"}, {30'h0, bus.ovf, bus.div0}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (repulse && (edge_cnt - k == 4)) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.acc_in = 16'd1; bus.opnd_in = 16'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!got) chk({name, ".timeout"}, 32'd1, 32'd0);
    else      chk({name, ".latency"}, edge_cnt - k, 32'd17);
    @(posedge CLK); #1;
    chk({name, ".busy_after"}, {30'h0, bus.busy, bus.done}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 chk({name, ".result_held"}, {16'h0, bus.result}, {16'h0, res});
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.acc_in = '0; bus.opnd_in = '0;
    #12;
    chk("reset.outputs", {26'h0, bus.busy, bus.done, bus.reg_w, bus.ovf, bus.div0, 1'b0}, 32'd0);
    chk("reset.result", {16'h0, bus.result}, 32'd0);
    @(negedge CLK); reset = 1'b0;

    run_op("mul_7_m3",      2'b00, 16'd7,    16'hFFFD, 16'hFFEB, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("mul_300_300",   2'b00, 16'd300,  16'd300,  16'h5F90, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("mul_min_1",     2'b00, 16'h8000, 16'd1,    16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("mul_min_m1",    2'b00, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("mul_0_m5",      2'b00, 16'd0,    16'hFFFB, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("mul_repulse",   2'b00, 16'hFFF6, 16'd12,   16'hFF88, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op("reserved_11",   2'b11, 16'd3,    16'd4,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ACC_MULDIV_DIV_EN
    run_op("div_m100_7",    2'b01, 16'hFF9C, 16'd7,    16'hFFF2, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("rem_m100_7",    2'b10, 16'hFF9C, 16'd7,    16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("div_5_0",       2'b01, 16'd5,    16'd0,    16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("rem_5_0",       2'b10, 16'd5,    16'd0,    16'h0005, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("mul_after_d0",  2'b00, 16'd2,    16'd3,    16'h0006, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("div_min_m1",    2'b01, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("div_10_2",      2'b01, 16'd10,   16'd2,    16'h0005, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    run_op("div_m100_7",    2'b01, 16'hFF9C, 16'd7,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("rem_5_0",       2'b10, 16'd5,    16'd0,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("div_10_2",      2'b01, 16'd10,   16'd2,    16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    run_op("mul_before_rst", 2'b00, 16'd9,   16'd9,    16'h0051, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset asserted asynchronously in the middle of RUN.
    begin
      int d0;
      d0 = done_cnt;
      @(negedge CLK);
      bus.start = 1'b1; bus.op = 2'b00; bus.acc_in = 16'd3; bus.opnd_in = 16'd4;
      @(posedge CLK); #1 bus.start = 1'b0;
      repeat (8) @(posedge CLK);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid.busy", {31'h0, bus.busy}, 32'd0);
      chk("rst_mid.result", {16'h0, bus.result}, 32'd0);
      chk("rst_mid.flags", {29'h0, bus.done, bus.reg_w, bus.ovf}, 32'd0);
      @(negedge CLK); reset = 1'b0;
      repeat (25) @(negedge CLK);
      chk("rst_mid.no_done", done_cnt - d0, 32'd0);
      chk("rst_mid.idle", {31'h0, bus.busy}, 32'd0);
    end

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
